// File: rtl/switch_led_ctrl.sv
// -----------------------------------------------------------------------------
// switch_led_ctrl
//   Sequences the four user LEDs from the four user switches. Each raw switch
//   is synchronised, debounced, and its debounced release (1->0) becomes a
//   one-cycle event. Switch 4 releases step a mode FSM through
//   TOGGLE -> CHASE -> BLINK -> OFF -> TOGGLE.
//
// Configuration macro:
//   SWITCH_LED_CTRL_SYNC2_EN  defined   : 2-flop synchroniser per switch
//                             undefined : single input flop per switch
//                                         (release latency one cycle shorter)
//
// Ports:
//   i_Clk      system clock
//   i_Rst      asynchronous, active-high reset
//   i_Switch   raw switch levels, bit0 = switch 1, 1 = pressed
//   o_LED      LED drive, bit0 = LED 1, 1 = lit (registered)
//   o_Mode     current mode: 00 TOGGLE, 01 CHASE, 10 BLINK, 11 OFF (registered)
//   o_Release  one-cycle debounced release pulses (registered)
// -----------------------------------------------------------------------------
module switch_led_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICK_CYCLES     = 6250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] i_Switch,
    output logic [3:0] o_LED,
    output logic [1:0] o_Mode,
    output logic [3:0] o_Release
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int TK_W = $clog2(TICK_CYCLES);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_CHASE  = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;

    // ------------------------------------------------------------------
    // Input synchronisation
    // ------------------------------------------------------------------
    logic [3:0] r_sync;

`ifdef SWITCH_LED_CTRL_SYNC2_EN
    logic [3:0] r_sync_meta;

    // Two-flop synchroniser for the asynchronous board switches
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_sync_meta <= 4'b0000;
            r_sync      <= 4'b0000;
        end else begin
            r_sync_meta <= i_Switch;
            r_sync      <= r_sync_meta;
        end
    end
`else
    // Single input flop for the board switches
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_sync <= 4'b0000;
        end else begin
            r_sync <= i_Switch;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Debouncers and release detection
    // ------------------------------------------------------------------
    logic [3:0]            r_stable;
    logic [3:0][DB_W-1:0]  r_db_cnt;
    logic [3:0]            r_release;
    logic [3:0]            w_stable_next;
    logic [3:0][DB_W-1:0]  w_db_cnt_next;
    logic [3:0]            w_release_next;

    // Per-switch debounce: count while the synchronised level disagrees with
    // the stable level; accept it on the last count. A release pulse is
    // raised in the same cycle the stable level drops, so the pulse and the
    // new stable level appear together.
    always_comb begin
        w_stable_next  = r_stable;
        w_db_cnt_next  = r_db_cnt;
        w_release_next = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            if (r_sync[n] == r_stable[n]) begin
                w_db_cnt_next[n] = {DB_W{1'b0}};
            end else if (r_db_cnt[n] == DB_LAST) begin
                w_stable_next[n]  = r_sync[n];
                w_db_cnt_next[n]  = {DB_W{1'b0}};
                w_release_next[n] = r_stable[n];
            end else begin
                w_db_cnt_next[n] = r_db_cnt[n] + DB_W'(1);
            end
        end
    end

    // Debounce state and registered release pulses
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_stable  <= 4'b0000;
            r_db_cnt  <= '{default: {DB_W{1'b0}}};
            r_release <= 4'b0000;
        end else begin
            r_stable  <= w_stable_next;
            r_db_cnt  <= w_db_cnt_next;
            r_release <= w_release_next;
        end
    end

    // ------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------
    logic [1:0] r_mode;
    logic [1:0] w_mode_next;
    logic       w_mode_change;

    assign w_mode_change = r_release[3];

    // Mode state register
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_mode <= MODE_TOGGLE;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    // Next mode: each switch-4 release advances one step around the ring
    always_comb begin
        w_mode_next = r_mode;
        if (w_mode_change) begin
            case (r_mode)
                MODE_TOGGLE: w_mode_next = MODE_CHASE;
                MODE_CHASE:  w_mode_next = MODE_BLINK;
                MODE_BLINK:  w_mode_next = MODE_OFF;
                MODE_OFF:    w_mode_next = MODE_TOGGLE;
                default:     w_mode_next = MODE_TOGGLE;
            endcase
        end else begin
            w_mode_next = r_mode;
        end
    end

    // ------------------------------------------------------------------
    // Pattern tick
    // ------------------------------------------------------------------
    logic [TK_W-1:0] r_tick_cnt;
    logic            w_tick_active;
    logic            w_tick;

    assign w_tick_active = (r_mode == MODE_CHASE) || (r_mode == MODE_BLINK);
    assign w_tick        = w_tick_active && (r_tick_cnt == TK_LAST);

    // Tick counter: runs only in CHASE/BLINK, restarts on every mode change
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_tick_cnt <= {TK_W{1'b0}};
        end else if (w_mode_change || !w_tick_active || w_tick) begin
            r_tick_cnt <= {TK_W{1'b0}};
        end else begin
            r_tick_cnt <= r_tick_cnt + TK_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    logic [2:0] r_toggle;
    logic       r_dir_down;
    logic [3:0] r_led;
    logic [2:0] w_toggle_next;
    logic       w_dir_down_next;
    logic [3:0] w_led_next;

    // LED/pattern update. Releases of switches 1-3 act on the current mode's
    // state first, so they still land when switch 4 leaves the mode in the
    // same cycle. A mode change overrides any tick with the entry pattern.
    always_comb begin
        w_toggle_next   = r_toggle;
        w_dir_down_next = r_dir_down;
        w_led_next      = r_led;

        case (r_mode)
            MODE_TOGGLE: w_toggle_next   = r_toggle ^ r_release[2:0];
            MODE_CHASE:  w_dir_down_next = r_dir_down ^ r_release[0];
            default:     w_toggle_next   = r_toggle;
        endcase

        if (w_mode_change) begin
            case (w_mode_next)
                MODE_TOGGLE: w_led_next = {1'b0, w_toggle_next};
                MODE_CHASE:  w_led_next = 4'b0001;
                MODE_BLINK:  w_led_next = 4'b1111;
                default:     w_led_next = 4'b0000;
            endcase
        end else if (r_mode == MODE_TOGGLE) begin
            w_led_next = {1'b0, w_toggle_next};
        end else if (r_mode == MODE_CHASE) begin
            // The direction flip only affects later ticks, never this cycle
            if (w_tick) begin
                w_led_next = r_dir_down ? {r_led[0], r_led[3:1]}
                                        : {r_led[2:0], r_led[3]};
            end else begin
                w_led_next = r_led;
            end
        end else if (r_mode == MODE_BLINK) begin
            if (w_tick) begin
                w_led_next = ~r_led;
            end else begin
                w_led_next = r_led;
            end
        end else begin
            w_led_next = 4'b0000;
        end
    end

    // Toggle bits, chase direction and LED drive registers
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_toggle   <= 3'b000;
            r_dir_down <= 1'b0;
            r_led      <= 4'b0000;
        end else begin
            r_toggle   <= w_toggle_next;
            r_dir_down <= w_dir_down_next;
            r_led      <= w_led_next;
        end
    end

    assign o_LED     = r_led;
    assign o_Mode    = r_mode;
    assign o_Release = r_release;

endmodule

// File: tb/tb_switch_led_ctrl.sv
module tb_switch_led_ctrl;

    localparam int DEB = 4;
    localparam int TCK = 8;
`ifdef SWITCH_LED_CTRL_SYNC2_EN
    localparam int LAT = DEB + 2;
`else
    localparam int LAT = DEB + 1;
`endif

    logic       i_Clk;
    logic       i_Rst;
    logic [3:0] i_Switch;
    logic [3:0] o_LED;
    logic [1:0] o_Mode;
    logic [3:0] o_Release;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    typedef struct {
        int         due;
        string      tag;
        logic [3:0] led;
        logic [1:0] mode;
    } led_exp_t;

    typedef struct {
        int         due;
        logic [3:0] rel;
    } rel_exp_t;

    led_exp_t led_q[$];
    rel_exp_t rel_q[$];

    switch_led_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_CYCLES    (TCK)
    ) dut (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Switch (i_Switch),
        .o_LED    (o_LED),
        .o_Mode   (o_Mode),
        .o_Release(o_Release)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Cycle index: number of rising edges seen so far
    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic exp_led(input int due, input string tag, input logic [3:0] led, input logic [1:0] mode);
        led_exp_t e;
        e.due = due; e.tag = tag; e.led = led; e.mode = mode;
        led_q.push_back(e);
    endtask

    task automatic exp_rel(input int due, input logic [3:0] rel);
        rel_exp_t e;
        e.due = due; e.rel = rel;
        rel_q.push_back(e);
    endtask

    // Scoreboard: release pulses checked every cycle, LED/mode when due
    always @(negedge i_Clk) begin : p_mon
        logic [3:0] rel_e;
        rel_e = 4'b0000;
        for (int i = rel_q.size() - 1; i >= 0; i--) begin
            if (rel_q[i].due == cyc) begin
                rel_e = rel_e | rel_q[i].rel;
                rel_q.delete(i);
            end
        end
        chk("release", 8'(o_Release), 8'(rel_e));
        for (int i = led_q.size() - 1; i >= 0; i--) begin
            if (led_q[i].due == cyc) begin
                chk({led_q[i].tag, "_led"},  8'(o_LED),  8'(led_q[i].led));
                chk({led_q[i].tag, "_mode"}, 8'(o_Mode), 8'(led_q[i].mode));
                led_q.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_Clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    // Press, hold 10 cycles, release; expect pulse and resulting LED/mode
    task automatic tap(input logic [3:0] m, input string tag, input logic [3:0] led_e, input logic [1:0] mode_e);
        int f;
        i_Switch = i_Switch | m;
        step(10);
        i_Switch = i_Switch & ~m;
        f = cyc;
        exp_rel(f + LAT, m);
        exp_led(f + LAT + 1, tag, led_e, mode_e);
        step(LAT + 3);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int e;
        int f;
        i_Rst    = 1'b1;
        i_Switch = 4'b0000;
        step(3);
        chk("rst_led",  8'(o_LED),     8'h00);
        chk("rst_mode", 8'(o_Mode),    8'h00);
        chk("rst_rel",  8'(o_Release), 8'h00);
        i_Rst = 1'b0;
        step(2);

        // TOGGLE: switch 1 twice, then bounced switch 2
        tap(4'b0001, "tog1_on",  4'b0001, 2'b00);
        tap(4'b0001, "tog1_off", 4'b0000, 2'b00);

        i_Switch = 4'b0010;
        step(10);
        i_Switch = 4'b0000; step(1);
        i_Switch = 4'b0010; step(1);
        i_Switch = 4'b0000; step(1);
        i_Switch = 4'b0010; step(1);
        i_Switch = 4'b0000;
        f = cyc;
        exp_rel(f + LAT, 4'b0010);
        exp_led(f + LAT,     "bounce_pre", 4'b0000, 2'b00);
        exp_led(f + LAT + 1, "bounce",     4'b0010, 2'b00);
        step(LAT + 3);

        // Build toggle = 101
        tap(4'b0010, "tog2_off", 4'b0000, 2'b00);
        tap(4'b0001, "tog1_on2", 4'b0001, 2'b00);
        tap(4'b0100, "tog3_on",  4'b0101, 2'b00);

        // CHASE: rotate up with wrap, then flip direction at 0001
        tap(4'b1000, "chase_in", 4'b0001, 2'b01);
        e = cyc - 2;
        exp_led(e + 7,  "ch_hold", 4'b0001, 2'b01);
        exp_led(e + 8,  "ch_t1",   4'b0010, 2'b01);
        exp_led(e + 16, "ch_t2",   4'b0100, 2'b01);
        exp_led(e + 24, "ch_t3",   4'b1000, 2'b01);
        exp_led(e + 31, "ch_pre4", 4'b1000, 2'b01);
        exp_led(e + 32, "ch_wrap", 4'b0001, 2'b01);
        wait_until(e + 20);
        i_Switch = 4'b0001;
        wait_until(e + 30);
        i_Switch = 4'b0000;
        exp_rel(e + 30 + LAT, 4'b0001);
        exp_led(e + 39, "ch_dir_hold", 4'b0001, 2'b01);
        exp_led(e + 40, "ch_down",     4'b1000, 2'b01);
        exp_led(e + 48, "ch_down2",    4'b0100, 2'b01);

        // Switch 4 release lands exactly on the tick at e+56
        f = e + 55 - LAT;
        wait_until(f - 10);
        i_Switch = 4'b1000;
        wait_until(f);
        i_Switch = 4'b0000;
        exp_rel(e + 55, 4'b1000);
        exp_led(e + 55, "blk_pre",  4'b0100, 2'b01);
        exp_led(e + 56, "blk_in",   4'b1111, 2'b10);
        exp_led(e + 63, "blk_hold", 4'b1111, 2'b10);
        exp_led(e + 64, "blk_t1",   4'b0000, 2'b10);
        exp_led(e + 72, "blk_t2",   4'b1111, 2'b10);
        exp_led(e + 80, "blk_t3",   4'b0000, 2'b10);
        wait_until(e + 82);

        // OFF: only switch 4 matters; toggle 101 restored on exit
        tap(4'b1000, "off_in", 4'b0000, 2'b11);
        tap(4'b0001, "off_s1", 4'b0000, 2'b11);
        tap(4'b0010, "off_s2", 4'b0000, 2'b11);
        tap(4'b0100, "off_s3", 4'b0000, 2'b11);
        tap(4'b1000, "tog_back", 4'b0101, 2'b00);

        // CHASE again: direction stayed down, then async reset mid-chase
        tap(4'b1000, "chase2_in", 4'b0001, 2'b01);
        e = cyc - 2;
        exp_led(e + 8, "ch2_down", 4'b1000, 2'b01);
        wait_until(e + 10);
        #2;
        i_Rst = 1'b1;
        #1;
        chk("arst_led",  8'(o_LED),     8'h00);
        chk("arst_mode", 8'(o_Mode),    8'h00);
        chk("arst_rel",  8'(o_Release), 8'h00);
        step(2);
        i_Rst = 1'b0;
        step(2);

        // After reset: direction back to up, toggle bits cleared
        tap(4'b1000, "chase3_in", 4'b0001, 2'b01);
        e = cyc - 2;
        exp_led(e + 8, "ch3_up", 4'b0010, 2'b01);
        wait_until(e + 10);
        tap(4'b1000, "blk3_in", 4'b1111, 2'b10);
        tap(4'b1000, "off3_in", 4'b0000, 2'b11);
        tap(4'b1000, "tog3_in", 4'b0000, 2'b00);

        step(2);
        chk("sb_drain", 8'(led_q.size() + rel_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
